image_buffer: RTL

IMAGE_BUFFER -- requirements
Module: image_buffer

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/bank_ram.sv | 39 +++
 rtl/image_buffer.sv | 101 ++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions.
//   DEF_DATA_WIDTH : default pixel word width
//   bank_state_t   : ping-pong bank lifecycle (EMPTY -> FILLING -> FULL -> READING -> EMPTY)
//   holds_frame()  : true when a bank holds a complete frame awaiting or under consumption
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    function automatic logic holds_frame(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_READING);
    endfunction

endpackage

// File: rtl/bank_ram.sv
// One frame bank: simple dual-port RAM, one write port, one registered read port.
//   clk, reset       : clock, async active-high reset (clears only the read register)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : read enable/address; read register holds when i_re = 0
//   o_rdata          : registered read data, 0 for addresses beyond DEPTH
module bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 16,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/image_buffer.sv
// Double-buffered frame store between a raster-order host writer and a conv2d reader.
//   clk, reset      : clock, async active-high reset
//   wr_data/wr_valid/wr_ready : host pixel stream into the current write bank
//   frame_loaded    : one-cycle pulse after the last word of a frame is committed
//   rd_enable       : consumer asks to start on the next full frame
//   rd_addr/rd_data : random read, one-cycle registered latency
//   input_valid     : the read bank is being served
//   conv_done       : consumer releases the read bank
//   frames_pending  : banks holding a complete frame (FULL or READING)
module image_buffer import cnn_pkg::*; #(
    parameter int INPUT_WIDTH    = 64,
    parameter int INPUT_HEIGHT   = 64,
    parameter int INPUT_CHANNELS = 1,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DEPTH          = INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS,
    parameter int AW             = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  frame_loaded,
    input  logic                  rd_enable,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  input_valid,
    input  logic                  conv_done,
    output logic [1:0]            frames_pending
);

    bank_state_t           r_state [2];
    logic                  r_wb;
    logic                  r_rb;
    logic                  r_rd_bank;      // bank whose read register drives rd_data
    logic                  r_frame_loaded;
    logic [AW-1:0]         r_wa;

    logic                  w_wr_ready;
    logic                  w_wr_fire;
    logic                  w_wr_last;
    logic                  w_reading;
    logic                  w_rd_start;
    logic                  w_rd_done;
    logic [DATA_WIDTH-1:0] w_q [2];

    assign w_wr_ready = (r_state[r_wb] == BANK_EMPTY) || (r_state[r_wb] == BANK_FILLING);
    assign w_wr_fire  = wr_valid && w_wr_ready;
    assign w_wr_last  = w_wr_fire && (r_wa == AW'(DEPTH - 1));
    assign w_reading  = (r_state[r_rb] == BANK_READING);
    assign w_rd_start = (r_state[r_rb] == BANK_FULL) && rd_enable;
    assign w_rd_done  = w_reading && conv_done;

    // Write side only touches an EMPTY/FILLING bank and read side only a
    // FULL/READING one, so the two updates below never hit the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0]     <= BANK_EMPTY;
            r_state[1]     <= BANK_EMPTY;
            r_wb           <= 1'b0;
            r_rb           <= 1'b0;
            r_wa           <= '0;
            r_rd_bank      <= 1'b0;
            r_frame_loaded <= 1'b0;
        end else begin
            r_frame_loaded <= w_wr_last;
            if (w_wr_fire) begin
                r_state[r_wb] <= w_wr_last ? BANK_FULL : BANK_FILLING;
                r_wa          <= w_wr_last ? '0 : r_wa + 1'b1;
                if (w_wr_last) r_wb <= ~r_wb;
            end
            if (w_rd_start) r_state[r_rb] <= BANK_READING;
            if (w_rd_done) begin
                r_state[r_rb] <= BANK_EMPTY;
                r_rb          <= ~r_rb;
            end
            // Remember the serving bank so rd_data holds after rb moves on.
            if (w_reading) r_rd_bank <= r_rb;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bank_ram #(.DEPTH(DEPTH), .DW(DATA_WIDTH), .AW(AW)) u_ram (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_wr_fire && (r_wb == 1'(b))),
            .i_waddr (r_wa),
            .i_wdata (wr_data),
            .i_re    (w_reading && (r_rb == 1'(b))),
            .i_raddr (rd_addr),
            .o_rdata (w_q[b])
        );
    end

    assign wr_ready       = w_wr_ready;
    assign frame_loaded   = r_frame_loaded;
    assign input_valid    = w_reading;
    assign rd_data        = w_q[r_rd_bank];
    assign frames_pending = {1'b0, holds_frame(r_state[0])} + {1'b0, holds_frame(r_state[1])};

endmodule
